// File: rtl/wb_pkg.sv
// wb_pkg: shared types for the MEM/WB latch and write-back mux.
// Word and register-address widths here must match the WORD_W/REG_AW
// parameters of writeback_stage, because the latch struct is built from them.
package wb_pkg;

    localparam int WB_WORD_W = 32;
    localparam int WB_REG_AW = 5;

    typedef logic [WB_WORD_W-1:0] word_t;
    typedef logic [WB_REG_AW-1:0] regbits_t;

    // Write-back source select. Code 2'b11 is reserved and selects zero.
    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_NPC = 2'd2
    } wb_sel_t;

    // Contents of the MEM/WB pipeline latch.
    typedef struct packed {
        logic     valid;
        logic     wen;
        regbits_t wsel;
        wb_sel_t  wb_sel;
        word_t    alu_res;
        word_t    load_dat;
        word_t    npc;
        logic     halt;
    } wb_latch_t;

    // Pick the write-back data for a latched instruction.
    function automatic word_t wb_mux(input wb_latch_t l);
        word_t d;
        case (l.wb_sel)
            WB_ALU:  d = l.alu_res;
            WB_MEM:  d = l.load_dat;
            WB_NPC:  d = l.npc;
            default: d = '0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/wb_retire_counter.sv
// wb_retire_counter: retired-instruction counter with enable, async
// active-low reset, wrapping modulo 2^WIDTH.
module wb_retire_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    // Count one per enabled cycle; natural overflow provides the wrap.
    always_ff @(posedge clk or negedge n_rst) begin
        // NOTE: sequential state uses non-blocking assignment so every flop
        // samples pre-edge values regardless of block ordering.
        if (!n_rst) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// writeback_stage: MEM/WB pipeline latch, register-file write port mux,
// sticky halt and retired-instruction counter.
// Optional feature: define WB_FWD_EN to add fwd_valid/fwd_wsel/fwd_wdat
// outputs (copies of the write port) for the WB->EX bypass.
module writeback_stage
    import wb_pkg::*;
#(
    parameter int WORD_W = WB_WORD_W,
    parameter int REG_AW = WB_REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              wb_stall,
    input  logic              wb_flush,
    input  logic              mem_valid,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_wsel,
    input  logic [1:0]        mem_wb_sel,
    input  logic [WORD_W-1:0] mem_alu_res,
    input  logic [WORD_W-1:0] mem_load_dat,
    input  logic [WORD_W-1:0] mem_npc,
    input  logic              mem_halt,
    output logic              rf_wen,
    output logic [REG_AW-1:0] rf_wsel,
    output logic [WORD_W-1:0] rf_wdat,
    output logic              halt,
    output logic [CNT_W-1:0]  retired
`ifdef WB_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [REG_AW-1:0] fwd_wsel,
    output logic [WORD_W-1:0] fwd_wdat
`endif
);

    wb_latch_t lat;
    logic      halt_set;
    logic      retire_en;

    // The halting instruction leaves WB on this edge; halt becomes sticky.
    assign halt_set  = lat.valid & lat.halt & ~wb_stall;
    // An instruction leaves WB on any unstalled edge before halt.
    assign retire_en = lat.valid & ~wb_stall & ~halt;

    // MEM/WB latch: halt freezes (and empties) it, then flush, then stall.
    // Halt is applied on the same edge it is set so nothing younger than
    // HALT ever reaches the write port.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            lat <= '0;
        end else if (halt || halt_set) begin
            lat.valid <= 1'b0;
        end else if (wb_flush) begin
            lat.valid <= 1'b0;
        end else if (!wb_stall) begin
            lat <= '{valid:    mem_valid,
                     wen:      mem_wen,
                     wsel:     mem_wsel,
                     wb_sel:   wb_sel_t'(mem_wb_sel),
                     alu_res:  mem_alu_res,
                     load_dat: mem_load_dat,
                     npc:      mem_npc,
                     halt:     mem_halt};
        end
    end

    // Sticky halt, cleared only by reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            halt <= 1'b0;
        end else if (halt_set) begin
            halt <= 1'b1;
        end
    end

    // Register-file write port, purely combinational from the latch.
    // r0 writes and the HALT instruction itself are suppressed here.
    always_comb begin
        // NOTE: every output gets a default first so no path through this
        // block leaves a signal unassigned (which would infer a latch).
        rf_wen  = 1'b0;
        rf_wsel = lat.wsel;
        rf_wdat = wb_mux(lat);
        if (lat.valid && lat.wen && !lat.halt && (lat.wsel != '0)) begin
            rf_wen = 1'b1;
        end
    end

    wb_retire_counter #(
        .WIDTH (CNT_W)
    ) u_retire_counter (
        .clk   (clk),
        .n_rst (n_rst),
        .en    (retire_en),
        .count (retired)
    );

`ifdef WB_FWD_EN
    assign fwd_valid = rf_wen;
    assign fwd_wsel  = rf_wsel;
    assign fwd_wdat  = rf_wdat;
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// tb_writeback_stage: directed, table-driven bench for writeback_stage.
// A second instance with a 4-bit counter exercises the retired-count wrap.
module tb_writeback_stage;

    localparam bit Y = 1'b1;
    localparam bit N = 1'b0;

    logic        clk;
    logic        n_rst;
    logic        wb_stall;
    logic        wb_flush;
    logic        mem_valid;
    logic        mem_wen;
    logic [4:0]  mem_wsel;
    logic [1:0]  mem_wb_sel;
    logic [31:0] mem_alu_res;
    logic [31:0] mem_load_dat;
    logic [31:0] mem_npc;
    logic        mem_halt;

    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        halt;
    logic [31:0] retired;

    logic        rf_wen4;
    logic [4:0]  rf_wsel4;
    logic [31:0] rf_wdat4;
    logic        halt4;
    logic [3:0]  retired4;

`ifdef WB_FWD_EN
    logic        fwd_valid,  fwd_valid4;
    logic [4:0]  fwd_wsel,   fwd_wsel4;
    logic [31:0] fwd_wdat,   fwd_wdat4;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    writeback_stage #(.WORD_W(32), .REG_AW(5), .CNT_W(32)) u_dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .wb_stall     (wb_stall),
        .wb_flush     (wb_flush),
        .mem_valid    (mem_valid),
        .mem_wen      (mem_wen),
        .mem_wsel     (mem_wsel),
        .mem_wb_sel   (mem_wb_sel),
        .mem_alu_res  (mem_alu_res),
        .mem_load_dat (mem_load_dat),
        .mem_npc      (mem_npc),
        .mem_halt     (mem_halt),
        .rf_wen       (rf_wen),
        .rf_wsel      (rf_wsel),
        .rf_wdat      (rf_wdat),
        .halt         (halt),
        .retired      (retired)
`ifdef WB_FWD_EN
        ,
        .fwd_valid    (fwd_valid),
        .fwd_wsel     (fwd_wsel),
        .fwd_wdat     (fwd_wdat)
`endif
    );

    writeback_stage #(.WORD_W(32), .REG_AW(5), .CNT_W(4)) u_dut4 (
        .clk          (clk),
        .n_rst        (n_rst),
        .wb_stall     (wb_stall),
        .wb_flush     (wb_flush),
        .mem_valid    (mem_valid),
        .mem_wen      (mem_wen),
        .mem_wsel     (mem_wsel),
        .mem_wb_sel   (mem_wb_sel),
        .mem_alu_res  (mem_alu_res),
        .mem_load_dat (mem_load_dat),
        .mem_npc      (mem_npc),
        .mem_halt     (mem_halt),
        .rf_wen       (rf_wen4),
        .rf_wsel      (rf_wsel4),
        .rf_wdat      (rf_wdat4),
        .halt         (halt4),
        .retired      (retired4)
`ifdef WB_FWD_EN
        ,
        .fwd_valid    (fwd_valid4),
        .fwd_wsel     (fwd_wsel4),
        .fwd_wdat     (fwd_wdat4)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        string       name;
        logic        stall;
        logic        flush;
        logic        valid;
        logic        wen;
        logic [4:0]  wsel;
        logic [1:0]  sel;
        logic [31:0] alu;
        logic [31:0] ld;
        logic [31:0] npc;
        logic        hlt;
        logic        e_wen;
        logic [4:0]  e_wsel;
        logic [31:0] e_wdat;
        logic        chk_dat;
        logic [31:0] e_ret;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_in(input logic stall, input logic flush, input logic valid,
                          input logic wen, input logic [4:0] wsel, input logic [1:0] sel,
                          input logic [31:0] alu, input logic [31:0] ld,
                          input logic [31:0] npc, input logic hlt);
        wb_stall     = stall;
        wb_flush     = flush;
        mem_valid    = valid;
        mem_wen      = wen;
        mem_wsel     = wsel;
        mem_wb_sel   = sel;
        mem_alu_res  = alu;
        mem_load_dat = ld;
        mem_npc      = npc;
        mem_halt     = hlt;
    endtask

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // name, stall, flush, valid, wen, wsel, sel, alu, ld, npc, hlt,
        // e_wen, e_wsel, e_wdat, chk_dat, e_ret
        vecs[0]  = '{"alu_w5",     N, N, Y, Y, 5'd5,  2'd0, 32'hDEADBEEF, 32'h0,  32'h0,   N, Y, 5'd5,  32'hDEADBEEF, Y, 32'd0};
        vecs[1]  = '{"jal_w31",    N, N, Y, Y, 5'd31, 2'd2, 32'h11,       32'h22, 32'h104, N, Y, 5'd31, 32'h104,      Y, 32'd1};
        vecs[2]  = '{"jal_w0",     N, N, Y, Y, 5'd0,  2'd2, 32'h11,       32'h22, 32'h104, N, N, 5'd0,  32'h104,      Y, 32'd2};
        vecs[3]  = '{"load_w7",    N, N, Y, Y, 5'd7,  2'd1, 32'h99,       32'h55, 32'h8,   N, Y, 5'd7,  32'h55,       Y, 32'd3};
        vecs[4]  = '{"rsvd_sel",   N, N, Y, Y, 5'd9,  2'd3, 32'h1,        32'h2,  32'h3,   N, Y, 5'd9,  32'h0,        Y, 32'd4};
        vecs[5]  = '{"not_valid",  N, N, N, Y, 5'd4,  2'd0, 32'hAA,       32'h0,  32'h0,   N, N, 5'd4,  32'hAA,       Y, 32'd5};
        vecs[6]  = '{"no_wen",     N, N, Y, N, 5'd6,  2'd0, 32'h12,       32'h0,  32'h0,   N, N, 5'd6,  32'h12,       Y, 32'd5};
        vecs[7]  = '{"load_w10",   N, N, Y, Y, 5'd10, 2'd1, 32'h0,        32'h55, 32'h0,   N, Y, 5'd10, 32'h55,       Y, 32'd6};
        vecs[8]  = '{"stall_fl",   Y, Y, Y, Y, 5'd11, 2'd0, 32'h77,       32'h0,  32'h0,   N, N, 5'd0,  32'h0,        N, 32'd6};
        vecs[9]  = '{"reload_w10", N, N, Y, Y, 5'd10, 2'd1, 32'h0,        32'h55, 32'h0,   N, Y, 5'd10, 32'h55,       Y, 32'd6};
        vecs[10] = '{"stall1",     Y, N, Y, Y, 5'd3,  2'd0, 32'hBAD,      32'h0,  32'h0,   N, Y, 5'd10, 32'h55,       Y, 32'd6};
        vecs[11] = '{"stall2",     Y, N, Y, Y, 5'd3,  2'd0, 32'hBAD,      32'h0,  32'h0,   N, Y, 5'd10, 32'h55,       Y, 32'd6};
        vecs[12] = '{"stall3",     Y, N, Y, Y, 5'd3,  2'd0, 32'hBAD,      32'h0,  32'h0,   N, Y, 5'd10, 32'h55,       Y, 32'd6};
        vecs[13] = '{"bubble",     N, N, N, N, 5'd0,  2'd0, 32'h0,        32'h0,  32'h0,   N, N, 5'd0,  32'h0,        Y, 32'd7};
        vecs[14] = '{"flush",      N, Y, Y, Y, 5'd12, 2'd0, 32'h5,        32'h0,  32'h0,   N, N, 5'd0,  32'h0,        N, 32'd7};

        // Reset state.
        n_rst = 1'b0;
        set_in(N, N, N, N, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, N);
        tick();
        tick();
        check("rst.rf_wen",  {31'd0, rf_wen},  32'd0);
        check("rst.rf_wsel", {27'd0, rf_wsel}, 32'd0);
        check("rst.rf_wdat", rf_wdat,          32'd0);
        check("rst.halt",    {31'd0, halt},    32'd0);
        check("rst.retired", retired,          32'd0);
        n_rst = 1'b1;

        // Table-driven single-cycle vectors.
        for (int i = 0; i < 15; i++) begin
            set_in(vecs[i].stall, vecs[i].flush, vecs[i].valid, vecs[i].wen, vecs[i].wsel,
                   vecs[i].sel, vecs[i].alu, vecs[i].ld, vecs[i].npc, vecs[i].hlt);
            tick();
            check($sformatf("%s.rf_wen", vecs[i].name), {31'd0, rf_wen}, {31'd0, vecs[i].e_wen});
            if (vecs[i].chk_dat) begin
                check($sformatf("%s.rf_wsel", vecs[i].name), {27'd0, rf_wsel}, {27'd0, vecs[i].e_wsel});
                check($sformatf("%s.rf_wdat", vecs[i].name), rf_wdat, vecs[i].e_wdat);
            end
            check($sformatf("%s.halt", vecs[i].name), {31'd0, halt}, 32'd0);
            check($sformatf("%s.retired", vecs[i].name), retired, vecs[i].e_ret);
        end

        // HALT enters WB; halt rises one edge later, HALT itself counted.
        set_in(N, N, Y, N, 5'd0, 2'd0, 32'h0, 32'h0, 32'h0, Y);
        tick();
        check("halt_in.halt",    {31'd0, halt},   32'd0);
        check("halt_in.rf_wen",  {31'd0, rf_wen}, 32'd0);
        check("halt_in.retired", retired,         32'd7);
        set_in(N, N, Y, Y, 5'd8, 2'd0, 32'h1234, 32'h0, 32'h0, N);
        tick();
        check("halt_set.halt",    {31'd0, halt},   32'd1);
        check("halt_set.rf_wen",  {31'd0, rf_wen}, 32'd0);
        check("halt_set.retired", retired,         32'd8);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("halted%0d.halt", k),    {31'd0, halt},   32'd1);
            check($sformatf("halted%0d.rf_wen", k),  {31'd0, rf_wen}, 32'd0);
            check($sformatf("halted%0d.retired", k), retired,         32'd8);
        end

        // Asynchronous reset mid-cycle clears halt and counter at once.
        #2;
        n_rst = 1'b0;
        #1;
        check("arst1.halt",    {31'd0, halt},   32'd0);
        check("arst1.retired", retired,         32'd0);
        check("arst1.rf_wen",  {31'd0, rf_wen}, 32'd0);
        set_in(N, N, Y, Y, 5'd5, 2'd0, 32'hDEADBEEF, 32'h0, 32'h0, N);
        n_rst = 1'b1;
        tick();
        check("post_rst.rf_wen",  {31'd0, rf_wen}, 32'd1);
        check("post_rst.rf_wdat", rf_wdat,         32'hDEADBEEF);
        // Reset with a write pending: write port drops immediately.
        #2;
        n_rst = 1'b0;
        #1;
        check("arst2.rf_wen",  {31'd0, rf_wen},  32'd0);
        check("arst2.rf_wsel", {27'd0, rf_wsel}, 32'd0);
        check("arst2.rf_wdat", rf_wdat,          32'd0);
        tick();
        check("arst2_edge.rf_wen",  {31'd0, rf_wen}, 32'd0);
        check("arst2_edge.retired", retired,         32'd0);
        n_rst = 1'b1;

        // Counter wrap on the 4-bit instance: 17 edges of valid traffic
        // retire 16 instructions (the first edge only fills the latch).
        set_in(N, N, Y, Y, 5'd1, 2'd0, 32'h1, 32'h0, 32'h0, N);
        for (int k = 0; k < 16; k++) begin
            tick();
        end
        check("wrap_pre.retired4", {28'd0, retired4}, 32'd15);
        check("wrap_pre.retired",  retired,           32'd15);
        tick();
        check("wrap.retired4", {28'd0, retired4}, 32'd0);
        check("wrap.retired",  retired,           32'd16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
